// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Holds the FSM state encoding, default widths and the high-byte reserved-bit mask.
package prog_loader_pkg;

  localparam int DEFAULT_ADDR_W  = 5;
  localparam int DEFAULT_INSTR_W = 14;

  // Only the low six bits of a high byte carry instruction bits; the rest must be zero.
  localparam logic [7:0] HI_RSVD_MASK = 8'hC0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: count byte, N high/low word pairs, XOR checksum.
// Writes each word to program memory as it arrives and stalls the CPU while loading.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int INSTR_W   = DEFAULT_INSTR_W,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  // One extra bit so a full MAX_WORDS load reaches index == N without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] index;
  logic [CNT_W-1:0] idx_next;
  logic [CNT_W-1:0] count;
  logic [5:0]       hi_bits;
  logic [7:0]       csum;
  logic             accept;
  logic             count_ok;
  logic             hi_ok;

  assign accept   = rx_valid & rx_ready;
  assign idx_next = index + 1'b1;
  assign count_ok = (rx_data != 8'd0) && (int'(rx_data) <= MAX_WORDS);
  assign hi_ok    = (rx_data & HI_RSVD_MASK) == 8'd0;

  always_ff @(posedge clock) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = S_COUNT;
      end
      S_COUNT: begin
        if (accept) state_next = count_ok ? S_HI : S_ERR;
      end
      S_HI: begin
        if (accept) state_next = hi_ok ? S_LO : S_ERR;
      end
      S_LO: begin
        if (accept) state_next = (idx_next < count) ? S_HI : S_CHK;
      end
      S_CHK: begin
        if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      S_COUNT, S_HI, S_LO, S_CHK: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      S_ERR: begin
        cpu_hold = 1'b1;
        err      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: index, stored count, high-byte bits, running checksum and write port.
  // Reset wins over a concurrent low-byte accept, so an aborted load never pulses wr_en.
  always_ff @(posedge clock) begin
    if (!rst) begin
      index   <= '0;
      count   <= '0;
      hi_bits <= '0;
      csum    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            index <= '0;
            csum  <= '0;
          end
        end
        S_COUNT: begin
          if (accept) begin
            count <= CNT_W'(rx_data);
            csum  <= csum ^ rx_data;
          end
        end
        S_HI: begin
          if (accept && hi_ok) begin
            hi_bits <= rx_data[5:0];
            csum    <= csum ^ rx_data;
          end
        end
        S_LO: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= index[ADDR_W-1:0];
            wr_data <= INSTR_W'({hi_bits, rx_data});
            index   <= idx_next;
            csum    <= csum ^ rx_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: normal, bad-checksum, bad-count,
// bad-high-byte, full 32-word load with gaps, and mid-load reset scenarios.
module tb_prog_loader;

  logic        clock;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [13:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks;
  int errors;

  logic [4:0]  wa_q[$];
  logic [13:0] wd_q[$];

  prog_loader dut (
    .clock   (clock),
    .rst     (rst),
    .start   (start),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every cycle with wr_en high is one recorded write.
  always @(negedge clock) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  // Offer one byte and hold it until the loader accepts it (bounded wait).
  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    for (int i = 0; i < gap; i++) @(negedge clock);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check_output("byte_accepted", 32'(rx_ready), 32'd1);
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input int k, input logic [4:0] addr, input logic [13:0] data);
    if (wa_q.size() > k) begin
      check_output({tag, "_addr"}, 32'(wa_q[k]), 32'(addr));
      check_output({tag, "_data"}, 32'(wd_q[k]), 32'(data));
    end else begin
      check_output({tag, "_present"}, 32'(wa_q.size()), 32'(k + 1));
    end
  endtask

  logic [7:0] model_sum;
  logic [7:0] lo_b;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle_cycles(3);

    // Reset state
    check_output("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_output("rst_wr_en",    32'(wr_en),    32'd0);
    check_output("rst_wr_addr",  32'(wr_addr),  32'd0);
    check_output("rst_wr_data",  32'(wr_data),  32'd0);
    check_output("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("rst_done",     32'(done),     32'd0);
    check_output("rst_err",      32'(err),      32'd0);
    @(negedge clock);
    rst = 1'b1;

    // rx_valid while idle must be ignored
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    idle_cycles(3);
    check_output("idle_rx_ready", 32'(rx_ready), 32'd0);
    check_output("idle_cpu_hold", 32'(cpu_hold), 32'd0);
    rx_valid = 1'b0;

    // Normal load
    $display("[TB] normal load");
    clear_writes();
    pulse_start();
    check_output("start_rx_ready", 32'(rx_ready), 32'd1);
    check_output("start_cpu_hold", 32'(cpu_hold), 32'd1);
    apply_stimulus(8'h02, 0);
    apply_stimulus(8'h3F, 0);
    apply_stimulus(8'hFF, 0);
    apply_stimulus(8'h00, 0);
    apply_stimulus(8'h01, 0);
    apply_stimulus(8'hC3, 0);
    check_output("norm_done",     32'(done),     32'd1);
    check_output("norm_err",      32'(err),      32'd0);
    check_output("norm_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("norm_rx_ready", 32'(rx_ready), 32'd0);
    check_output("norm_nwrites",  32'(wa_q.size()), 32'd2);
    check_write("norm_w0", 0, 5'd0, 14'h3FFF);
    check_write("norm_w1", 1, 5'd1, 14'h0001);
    check_output("norm_hold_addr", 32'(wr_addr), 32'd1);
    check_output("norm_hold_data", 32'(wr_data), 32'h0001);

    // Bad checksum
    $display("[TB] bad checksum");
    clear_writes();
    pulse_start();
    check_output("bad_done_cleared", 32'(done), 32'd0);
    apply_stimulus(8'h02, 0);
    apply_stimulus(8'h3F, 0);
    apply_stimulus(8'hFF, 0);
    apply_stimulus(8'h00, 0);
    apply_stimulus(8'h01, 0);
    apply_stimulus(8'h00, 0);
    check_output("badck_err",      32'(err),      32'd1);
    check_output("badck_done",     32'(done),     32'd0);
    check_output("badck_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("badck_nwrites",  32'(wa_q.size()), 32'd2);
    check_write("badck_w0", 0, 5'd0, 14'h3FFF);
    check_write("badck_w1", 1, 5'd1, 14'h0001);

    // Count out of range
    $display("[TB] bad count");
    clear_writes();
    pulse_start();
    check_output("cnt_err_cleared", 32'(err), 32'd0);
    apply_stimulus(8'h21, 0);
    check_output("cnt_err",      32'(err),      32'd1);
    check_output("cnt_rx_ready", 32'(rx_ready), 32'd0);
    idle_cycles(2);
    check_output("cnt_nwrites",  32'(wa_q.size()), 32'd0);

    // Zero count
    clear_writes();
    pulse_start();
    apply_stimulus(8'h00, 0);
    check_output("cnt0_err", 32'(err), 32'd1);

    // High byte with reserved bits set
    $display("[TB] bad high byte");
    clear_writes();
    pulse_start();
    apply_stimulus(8'h01, 0);
    apply_stimulus(8'h40, 0);
    check_output("hi_err",      32'(err),      32'd1);
    check_output("hi_rx_ready", 32'(rx_ready), 32'd0);
    idle_cycles(2);
    check_output("hi_nwrites",  32'(wa_q.size()), 32'd0);

    // Full 32-word load with gaps, plus a start pulse mid-load that must be ignored
    $display("[TB] full load");
    clear_writes();
    pulse_start();
    model_sum = 8'h20;
    apply_stimulus(8'h20, 1);
    for (int i = 0; i < 32; i++) begin
      lo_b = 8'(i * 7 + 3);
      apply_stimulus(8'(i), i % 3);
      if (i == 10) pulse_start();
      apply_stimulus(lo_b, (i + 1) % 2);
      model_sum = model_sum ^ 8'(i) ^ lo_b;
    end
    idle_cycles(1);
    check_output("full_in_chk", 32'(rx_ready), 32'd1);
    apply_stimulus(model_sum, 2);
    check_output("full_done",    32'(done),     32'd1);
    check_output("full_err",     32'(err),      32'd0);
    check_output("full_nwrites", 32'(wa_q.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      lo_b = 8'(i * 7 + 3);
      check_write($sformatf("full_w%0d", i), i, 5'(i), {6'(i), lo_b});
    end

    // Reset between high and low bytes
    $display("[TB] mid-load reset");
    clear_writes();
    pulse_start();
    apply_stimulus(8'h01, 0);
    apply_stimulus(8'h3F, 0);
    @(negedge clock);
    rst = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(posedge clock);
    #1;
    rst = 1'b1;
    rx_valid = 1'b0;
    check_output("mrst_rx_ready", 32'(rx_ready), 32'd0);
    check_output("mrst_wr_en",    32'(wr_en),    32'd0);
    check_output("mrst_wr_addr",  32'(wr_addr),  32'd0);
    check_output("mrst_wr_data",  32'(wr_data),  32'd0);
    check_output("mrst_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("mrst_done",     32'(done),     32'd0);
    check_output("mrst_err",      32'(err),      32'd0);
    idle_cycles(2);
    check_output("mrst_nwrites",  32'(wa_q.size()), 32'd0);
    pulse_start();
    apply_stimulus(8'h01, 0);
    apply_stimulus(8'h12, 0);
    apply_stimulus(8'h34, 0);
    apply_stimulus(8'h27, 0);
    check_output("restart_done",    32'(done), 32'd1);
    check_output("restart_nwrites", 32'(wa_q.size()), 32'd1);
    check_write("restart_w0", 0, 5'd0, 14'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 5, program-memory address width.
REQ-002 Parameter INSTR_W, default 14, instruction word width.
REQ-003 Parameter MAX_WORDS, default 32, maximum words per load (2**ADDR_W).
REQ-004 clock  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 start  input  1  level sampled each cycle; begins a load when in IDLE, DONE or ERR.
REQ-007 rx_data  input  8  incoming byte.
REQ-008 rx_valid  input  1  rx_data valid this cycle.
REQ-009 rx_ready  output  1  loader accepts a byte this cycle.
REQ-010 wr_en  output  1  one-cycle program-memory write strobe.
REQ-011 wr_addr  output  ADDR_W  write address.
REQ-012 wr_data  output  INSTR_W  instruction word to write.
REQ-013 cpu_hold  output  1  holds the processor stalled while loading.
REQ-014 done  output  1  last load completed with a good checksum.
REQ-015 err  output  1  last load aborted or failed its checksum.

Function
REQ-016 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-017 Stream format SHALL be: count byte N, then N word pairs (high byte, low byte), then one checksum byte.
REQ-018 FSM states SHALL be IDLE, COUNT, HI, LO, CHK, DONE and ERR.
REQ-019 IDLE/DONE/ERR with start=1 SHALL go to COUNT next cycle, clear done and err, and zero the word index.
REQ-020 rx_ready SHALL be 1 in COUNT, HI, LO and CHK, and 0 in all other states.
REQ-021 COUNT: an accepted N of 1..MAX_WORDS SHALL go to HI; N=0 or N>MAX_WORDS SHALL go to ERR.
REQ-022 HI: if accepted byte bits [7:6] are nonzero, the FSM SHALL go to ERR; otherwise it SHALL store bits [5:0] and go to LO.
REQ-023 LO: on an accepted byte, wr_en SHALL be 1 in the following cycle only, with wr_data = {stored high[5:0], low byte} and wr_addr = current index.
REQ-024 After each write the index SHALL increment; the FSM SHALL return to HI while index < N and go to CHK when index = N.
REQ-025 The running checksum SHALL be the 8-bit XOR of every accepted byte from count through the final low byte.
REQ-026 CHK: an accepted byte equal to the checksum SHALL go to DONE (done=1); any other value SHALL go to ERR (err=1).
REQ-027 Words written before an error SHALL NOT be rolled back; err alone signals an invalid image.
REQ-028 cpu_hold SHALL be 1 in COUNT, HI, LO, CHK and ERR, and 0 in IDLE and DONE.
REQ-029 start while in COUNT, HI, LO or CHK SHALL be ignored.
REQ-030 rx_valid with rx_ready=0 SHALL have no effect, and no byte SHALL be consumed.
REQ-031 Index arithmetic SHALL be ADDR_W+1 bits wide so that N=MAX_WORDS completes without wrap.
REQ-032 wr_addr and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-033 With rst=0 at a rising edge, the FSM SHALL enter IDLE; rx_ready, wr_en, cpu_hold, done and err SHALL be 0; wr_addr, wr_data, index and checksum SHALL be 0.
REQ-034 rst=0 mid-load SHALL abort immediately, with no further wr_en pulses.

Structure
REQ-035 A shared package SHALL hold the state enum, INSTR_W, ADDR_W and the HI-byte reserved-bit mask.
REQ-036 The design SHALL be a single module with no sub-modules; the FSM and datapath live together.

Verification
REQ-037 Normal load: start, then bytes 02,3F,FF,00,01 and checksum C3 -> writes addr0=0x3FFF, addr1=0x0001; done=1; cpu_hold falls after CHK.
REQ-038 Bad checksum: same stream with final byte 00 -> both writes occur; err=1; done=0; cpu_hold stays 1.
REQ-039 Count byte 0x21 -> ERR the next cycle; no wr_en pulse; rx_ready=0.
REQ-040 High byte 0x40 -> ERR; no write for that word.
REQ-041 Full load of N=32 with gaps in rx_valid -> 32 writes at addresses 0..31, no wrap, done=1.
REQ-042 rst=0 between HI and LO bytes -> IDLE with all outputs 0; a later start restarts from address 0.
